// File: rtl/button_detect.sv
// Push-button front end: synchronizes a raw button level, debounces it, and
// emits a single-cycle pulse on each accepted press.
module button_detect #(
  parameter int SYNC_STAGES     = 2,  // legal range 2..4
  parameter int DEBOUNCE_CYCLES = 1   // legal range 1..65535
) (
  input  logic clk_sys,
  input  logic rstn,
  input  logic button_in,
  output logic button_out
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   btn_s;
  logic                   stable;
  logic [CW-1:0]          cnt;

  assign btn_s = sync[SYNC_STAGES-1];

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // this keeps the sync chain a true shift register instead of collapsing it.
  always_ff @(posedge clk_sys) begin
    if (rstn) begin
      sync       <= '0;
      stable     <= 1'b0;
      cnt        <= '0;
      button_out <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], button_in};
      button_out <= 1'b0;
      if (btn_s == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // Level persisted long enough: accept it; only a press pulses.
        stable     <= btn_s;
        cnt        <= '0;
        button_out <= btn_s;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_button_detect.sv
// Bench for button_detect: a default instance and a DEBOUNCE_CYCLES=4 instance,
// checked every cycle against a sliding-window reference model plus directed totals.
module tb_button_detect;

  localparam int S_A = 2;
  localparam int D_A = 1;
  localparam int S_B = 2;
  localparam int D_B = 4;

  logic clk_sys = 1'b0;
  logic a_rst, a_in, a_out;
  logic b_rst, b_in, b_out;

  always #5 clk_sys = ~clk_sys;

  button_detect dut_a (
    .clk_sys   (clk_sys),
    .rstn      (a_rst),
    .button_in (a_in),
    .button_out(a_out)
  );

  button_detect #(
    .SYNC_STAGES    (S_B),
    .DEBOUNCE_CYCLES(D_B)
  ) dut_b (
    .clk_sys   (clk_sys),
    .rstn      (b_rst),
    .button_in (b_in),
    .button_out(b_out)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: raw-input history and synchronized-level history as bit
  // vectors (bit 0 newest). A new level is accepted when the last D
  // synchronized samples all disagree with the current debounced level.
  logic [63:0] m_rh     [2];
  logic [63:0] m_sh     [2];
  int          m_nv     [2];
  logic        m_stable [2];
  logic        m_pulse  [2];
  int          m_s      [2];
  int          m_d      [2];

  int ecnt, a_pulses, b_pulses, a_first, b_first;

  task automatic model(input int id, input logic din, input logic rst);
    logic        bs;
    logic [63:0] mask;
    if (rst) begin
      m_rh[id]     = '0;
      m_sh[id]     = '0;
      m_nv[id]     = 0;
      m_stable[id] = 1'b0;
      m_pulse[id]  = 1'b0;
    end else begin
      bs       = m_rh[id][m_s[id]-1];
      m_sh[id] = {m_sh[id][62:0], bs};
      if (m_nv[id] < 1000) m_nv[id]++;
      mask        = (64'd1 << m_d[id]) - 64'd1;
      m_pulse[id] = 1'b0;
      if (m_nv[id] >= m_d[id] &&
          (m_sh[id] & mask) == (m_stable[id] ? 64'd0 : mask)) begin
        m_stable[id] = ~m_stable[id];
        m_pulse[id]  = m_stable[id];
      end
      m_rh[id] = {m_rh[id][62:0], din};
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs == exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic begin_scn();
    ecnt     = 0;
    a_pulses = 0;
    b_pulses = 0;
    a_first  = -1;
    b_first  = -1;
  endtask

  // One clock: drive on the falling edge, model the rising edge, sample 1 ns later.
  task automatic step(input logic ai, input logic ar, input logic bi, input logic br);
    @(negedge clk_sys);
    a_in  = ai;
    a_rst = ar;
    b_in  = bi;
    b_rst = br;
    @(posedge clk_sys);
    model(0, ai, ar);
    model(1, bi, br);
    #1;
    ecnt++;
    check("a_out", a_out, m_pulse[0]);
    check("b_out", b_out, m_pulse[1]);
    check("a_stable", dut_a.stable, m_stable[0]);
    check("b_stable", dut_b.stable, m_stable[1]);
    if (a_out === 1'b1) begin
      a_pulses++;
      if (a_first < 0) a_first = ecnt;
    end
    if (b_out === 1'b1) begin
      b_pulses++;
      if (b_first < 0) b_first = ecnt;
    end
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int   ra_len, rb_len;
    logic ra, rb;

    m_s = '{S_A, S_B};
    m_d = '{D_A, D_B};
    model(0, 1'b0, 1'b1);
    model(1, 1'b0, 1'b1);
    a_rst = 1'b1; b_rst = 1'b1;
    a_in  = 1'b1; b_in  = 1'b1;

    // Reset with the button pressed: outputs must stay low.
    begin_scn();
    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    check_int("reset_pulses", a_pulses + b_pulses, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

    // Default build: one-edge press -> single pulse after edge 3, nothing after.
    begin_scn();
    step(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
    check_int("short_press_pulses", a_pulses, 1);
    check_int("short_press_edge", a_first, S_A + D_A);

    // Default build: long hold -> exactly one pulse.
    begin_scn();
    for (int i = 0; i < 30; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    check_int("hold_a_pulses", a_pulses, 1);
    check_int("hold_a_edge", a_first, S_A + D_A);

    // D=4: 3-cycle glitch is rejected.
    begin_scn();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    check_int("glitch_pulses", b_pulses, 0);

    // D=4: 50-cycle hold -> one pulse at edge 6.
    begin_scn();
    for (int i = 0; i < 50; i++) step(0, 0, 1, 0);
    check_int("hold_b_pulses", b_pulses, 1);
    check_int("hold_b_edge", b_first, S_B + D_B);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    check_int("release_no_pulse", b_pulses, 1);

    // D=4: press / release / press -> two pulses.
    begin_scn();
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    check_int("double_press_pulses", b_pulses, 2);

    // D=4: reset mid-count abandons it; held button is a new press afterwards.
    begin_scn();
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    check_int("reset_mid_count_pulses", b_pulses, 0);
    begin_scn();
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    check_int("after_reset_pulses", b_pulses, 1);
    check_int("after_reset_edge", b_first, S_B + D_B);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);

    // D=4: toggling every cycle never settles.
    begin_scn();
    for (int i = 0; i < 20; i++) step(0, 0, logic'(i % 2 == 0), 0);
    check_int("toggle_pulses", b_pulses, 0);
    check("toggle_stable", dut_b.stable, 1'b0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);

    // Random levels with random hold lengths and occasional resets.
    ra_len = 0; rb_len = 0; ra = 1'b0; rb = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (ra_len == 0) begin
        ra     = logic'($urandom_range(0, 1));
        ra_len = $urandom_range(1, 6);
      end
      if (rb_len == 0) begin
        rb     = logic'($urandom_range(0, 1));
        rb_len = $urandom_range(1, 8);
      end
      ra_len--;
      rb_len--;
      step(ra, logic'($urandom_range(0, 39) == 0),
           rb, logic'($urandom_range(0, 39) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
